// File: rtl/pc_pkg.sv
// Shared types for the PC generator: next-PC select encoding, FSM state
// encoding, and a word-alignment helper.
package pc_pkg;

    localparam int unsigned PCSRC_W = 2;

    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_INC    = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JALR   = 2'b10,
        PCSRC_TRAP   = 2'b11
    } pcsrc_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } pc_state_t;

    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control/status bundle for pc_gen.
//   master: drives en, PCsrc, ImmOp, ALUResult, fault_ack; observes PC,
//           PCPlus4, misaligned, fault_pc.
//   slave : the PC generator itself.
interface pc_gen_if #(
    parameter int unsigned WIDTH = 32
) ();
    import pc_pkg::*;

    logic                 en;
    logic [PCSRC_W-1:0]   PCsrc;
    logic [WIDTH-1:0]     ImmOp;
    logic [WIDTH-1:0]     ALUResult;
    logic                 fault_ack;
    logic [WIDTH-1:0]     PC;
    logic [WIDTH-1:0]     PCPlus4;
    logic                 misaligned;
    logic [WIDTH-1:0]     fault_pc;

    modport master (
        output en, PCsrc, ImmOp, ALUResult, fault_ack,
        input  PC, PCPlus4, misaligned, fault_pc
    );

    modport slave (
        input  en, PCsrc, ImmOp, ALUResult, fault_ack,
        output PC, PCPlus4, misaligned, fault_pc
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC target selection.
//   pc            : current PC
//   pcsrc         : target select
//   imm           : branch offset (two's complement)
//   alu_result    : jalr target before LSB clearing
//   pc_plus_inc_c : pc + INC
//   target_c      : selected target (modulo 2^WIDTH)
//   misalign_c    : target not word-aligned (branch/jalr only)
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  TRAP_VECTOR = WIDTH'(32'h0000_0100),
    parameter int unsigned       INC         = 4
) (
    input  logic [WIDTH-1:0] pc,
    input  pcsrc_t           pcsrc,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] pc_plus_inc_c,
    output logic [WIDTH-1:0] target_c,
    output logic             misalign_c
);

    // Sums are WIDTH wide so the carry out is dropped and the PC wraps.
    always_comb begin
        pc_plus_inc_c = pc + WIDTH'(INC);
        target_c      = pc_plus_inc_c;
        misalign_c    = 1'b0;
        case (pcsrc)
            PCSRC_INC: begin
                target_c = pc_plus_inc_c;
            end
            PCSRC_BRANCH: begin
                target_c   = pc + imm;
                misalign_c = !is_word_aligned(target_c[1:0]);
            end
            PCSRC_JALR: begin
                // jalr clears bit 0 only; bit 1 may still flag a fault.
                target_c   = alu_result & ~WIDTH'(1);
                misalign_c = !is_word_aligned(target_c[1:0]);
            end
            PCSRC_TRAP: begin
                target_c = TRAP_VECTOR;
            end
            default: begin
                target_c = pc_plus_inc_c;
            end
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator with misaligned-target fault capture.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_gen_if slave (en, PCsrc, ImmOp, ALUResult, fault_ack in;
//                PC, PCPlus4, misaligned, fault_pc out)
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(32'h0),
    parameter logic [WIDTH-1:0]  TRAP_VECTOR  = WIDTH'(32'h0000_0100),
    parameter int unsigned       INC          = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_gen_if.slave    bus
);

    // Trap targets bypass the alignment check, so they must be aligned.
    if (TRAP_VECTOR[1:0] != 2'b00) begin : g_trap_align_chk
        $error("pc_gen: TRAP_VECTOR must be word-aligned");
    end

    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] fault_pc_q, fault_pc_d;

    logic [WIDTH-1:0] pc_plus_inc_c;
    logic [WIDTH-1:0] target_c;
    logic             misalign_c;

    pc_next_sel #(
        .WIDTH       (WIDTH),
        .TRAP_VECTOR (TRAP_VECTOR),
        .INC         (INC)
    ) u_next_sel (
        .pc            (pc_q),
        .pcsrc         (pcsrc_t'(bus.PCsrc)),
        .imm           (bus.ImmOp),
        .alu_result    (bus.ALUResult),
        .pc_plus_inc_c (pc_plus_inc_c),
        .target_c      (target_c),
        .misalign_c    (misalign_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VECTOR;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // Next-state logic; en=0 leaves everything as is.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        case (state_q)
            ST_RUN: begin
                if (bus.en) begin
                    if (misalign_c) begin
                        fault_pc_d = target_c;
                        state_d    = ST_FAULT;
                    end else begin
                        pc_d = target_c;
                    end
                end
            end
            ST_FAULT: begin
                if (bus.en && bus.fault_ack) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign bus.PC         = pc_q;
    assign bus.PCPlus4    = pc_plus_inc_c;
    assign bus.misaligned = (state_q == ST_FAULT);
    assign bus.fault_pc   = fault_pc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: table of vectors with hand-derived
// expectations fed through a scoreboard queue, plus reset corner cases.
module tb_pc_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pc_gen_if #(.WIDTH(32)) bus ();

    pc_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        en;
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        ack;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] fpc;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] fpc;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input logic en, input logic [1:0] src, input logic [31:0] imm,
                       input logic [31:0] alu, input logic ack,
                       input logic [31:0] pc, input logic mis, input logic [31:0] fpc);
        vec_t v;
        v.en = en; v.src = src; v.imm = imm; v.alu = alu; v.ack = ack;
        v.pc = pc; v.mis = mis; v.fpc = fpc;
        vq.push_back(v);
    endtask

    task automatic drive(input logic en, input logic [1:0] src, input logic [31:0] imm,
                         input logic [31:0] alu, input logic ack);
        bus.en        = en;
        bus.PCsrc     = src;
        bus.ImmOp     = imm;
        bus.ALUResult = alu;
        bus.fault_ack = ack;
    endtask

    initial begin
        exp_t e;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst.pc",      bus.PC,                  32'h0);
        check("rst.pcplus4", bus.PCPlus4,             32'h4);
        check("rst.mis",     32'(bus.misaligned),     32'h0);
        check("rst.fpc",     bus.fault_pc,            32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset with en=0 must not update
        @(posedge clk); #1;
        check("post_rst_stall.pc", bus.PC, 32'h0);

        //   en    src    imm           alu           ack   pc            mis   fpc
        add(1'b1, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0000_0004, 1'b0, 32'h0);
        add(1'b1, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0000_0008, 1'b0, 32'h0);
        add(1'b1, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0000_000C, 1'b0, 32'h0);
        add(1'b1, 2'b10, 32'h0,        32'h21,       1'b0, 32'h0000_0020, 1'b0, 32'h0);
        add(1'b1, 2'b01, 32'hFFFF_FFF0, 32'h0,       1'b0, 32'h0000_0010, 1'b0, 32'h0);
        add(1'b1, 2'b10, 32'h0,        32'h41,       1'b0, 32'h0000_0040, 1'b0, 32'h0);
        add(1'b1, 2'b10, 32'h0,        32'h42,       1'b0, 32'h0000_0040, 1'b1, 32'h42);
        add(1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0040, 1'b1, 32'h42);
        add(1'b1, 2'b11, 32'h0,        32'h0,        1'b0, 32'h0000_0040, 1'b1, 32'h42);
        add(1'b1, 2'b01, 32'h4,        32'h0,        1'b1, 32'h0000_0100, 1'b0, 32'h42);
        add(1'b1, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0104, 1'b0, 32'h42);
        add(1'b1, 2'b01, 32'h6,        32'h0,        1'b0, 32'h0000_0104, 1'b1, 32'h10A);
        add(1'b1, 2'b10, 32'h0,        32'h80,       1'b1, 32'h0000_0100, 1'b0, 32'h10A);
        add(1'b1, 2'b10, 32'h0,        32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h10A);
        add(1'b1, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0000_0000, 1'b0, 32'h10A);
        for (int k = 0; k < 5; k++)
            add(1'b0, 2'b01, 32'h8,    32'h0,        1'b0, 32'h0000_0000, 1'b0, 32'h10A);
        add(1'b1, 2'b11, 32'h0,        32'h0,        1'b0, 32'h0000_0100, 1'b0, 32'h10A);
        add(1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0,       1'b0, 32'h0000_00FC, 1'b0, 32'h10A);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].en, vq[i].src, vq[i].imm, vq[i].alu, vq[i].ack);
            e.idx = i; e.pc = vq[i].pc; e.mis = vq[i].mis; e.fpc = vq[i].fpc;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            check($sformatf("v%0d.pc", e.idx),      bus.PC,              e.pc);
            check($sformatf("v%0d.mis", e.idx),     32'(bus.misaligned), 32'(e.mis));
            check($sformatf("v%0d.fpc", e.idx),     bus.fault_pc,        e.fpc);
            check($sformatf("v%0d.pcplus4", e.idx), bus.PCPlus4,         e.pc + 32'h4);
        end

        // Enter FAULT, then pulse reset mid-cycle
        @(negedge clk);
        drive(1'b1, 2'b10, 32'h0, 32'h142, 1'b0);
        @(posedge clk); #1;
        check("flt.mis", 32'(bus.misaligned), 32'h1);
        check("flt.fpc", bus.fault_pc,        32'h142);
        check("flt.pc",  bus.PC,              32'h0FC);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.pc",  bus.PC,              32'h0);
        check("midrst.mis", 32'(bus.misaligned), 32'h0);
        check("midrst.fpc", bus.fault_pc,        32'h0);
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_rst.pc", bus.PC, 32'h4);

        // Reset during a stall also wins
        @(negedge clk);
        drive(1'b0, 2'b01, 32'h40, 32'h0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("stallrst.pc", bus.PC, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
